// File: rtl/spike_dispatcher.sv
// spike_dispatcher: walks a captured spike vector once per timestep, emitting
// base_address + index for every set bit (lowest index first), then holds an
// end-of-timestep clear for CLEAR_CYCLES cycles and pulses done.
// Optional feature macro: SPIKE_DISPATCHER_COUNT_EN adds the spike_count
// output, counting addresses emitted in the current/last timestep.
// All outputs are registered; they are computed from the next-cycle state.
module spike_dispatcher #(
  parameter int                    NUM_NEURONS  = 32,
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    CLEAR_CYCLES = 2,
  parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR    = {ADDR_WIDTH{1'b1}}
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   timestep_start,
  input  logic [NUM_NEURONS-1:0] spike_vector,
  input  logic [ADDR_WIDTH-1:0]  base_address,
  output logic [ADDR_WIDTH-1:0]  source_address,
  output logic                   address_valid,
  output logic                   clear_out,
  output logic                   busy,
  output logic                   done
`ifdef SPIKE_DISPATCHER_COUNT_EN
  ,
  output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count
`endif
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r, nxt_state_s;
  logic [NUM_NEURONS-1:0] vec_r, nxt_vec_s;
  logic [ADDR_WIDTH-1:0]  base_r, nxt_base_s;
  logic [3:0]             clr_cnt_r, nxt_clr_cnt_s;
  logic                   nxt_valid_s;
  logic [ADDR_WIDTH-1:0]  nxt_addr_s;
  logic                   capture_s;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_NEURONS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Next-state, next captured data and next-cycle output values.
  always_comb begin
    nxt_state_s   = state_r;
    nxt_vec_s     = vec_r;
    nxt_base_s    = base_r;
    nxt_clr_cnt_s = clr_cnt_r;
    capture_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (timestep_start) begin
          capture_s   = 1'b1;
          nxt_state_s = SCAN;
          nxt_vec_s   = spike_vector;
          nxt_base_s  = base_address;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      SCAN: begin
        // Drop the bit being emitted this cycle; an empty vector stays empty.
        nxt_vec_s = vec_r & (vec_r - NUM_NEURONS'(1));
        if (nxt_vec_s == '0) begin
          nxt_state_s   = CLEAR;
          nxt_clr_cnt_s = 4'd0;
        end else begin
          nxt_state_s = SCAN;
        end
      end
      CLEAR: begin
        if (clr_cnt_r == 4'(CLEAR_CYCLES - 1)) begin
          nxt_state_s   = DONE;
          nxt_clr_cnt_s = 4'd0;
        end else begin
          nxt_clr_cnt_s = clr_cnt_r + 4'd1;
        end
      end
      DONE: begin
        nxt_state_s = IDLE;
      end
      default: begin
        nxt_state_s   = IDLE;
        nxt_vec_s     = '0;
        nxt_clr_cnt_s = 4'd0;
      end
    endcase
    nxt_valid_s = (nxt_state_s == SCAN) && (nxt_vec_s != '0);
    if (nxt_valid_s) begin
      nxt_addr_s = nxt_base_s + ADDR_WIDTH'(lowest_idx(nxt_vec_s));
    end else begin
      nxt_addr_s = IDLE_ADDR;
    end
  end

  // State, captured data and registered outputs; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      vec_r          <= '0;
      base_r         <= '0;
      clr_cnt_r      <= 4'd0;
      source_address <= IDLE_ADDR;
      address_valid  <= 1'b0;
      clear_out      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_r        <= nxt_state_s;
      vec_r          <= nxt_vec_s;
      base_r         <= nxt_base_s;
      clr_cnt_r      <= nxt_clr_cnt_s;
      source_address <= nxt_addr_s;
      address_valid  <= nxt_valid_s;
      clear_out      <= (nxt_state_s == CLEAR);
      busy           <= (nxt_state_s != IDLE);
      done           <= (nxt_state_s == DONE);
    end
  end

`ifdef SPIKE_DISPATCHER_COUNT_EN
  // Emitted-address counter: zeroed at capture, held until the next capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      spike_count <= '0;
    end else if (capture_s) begin
      spike_count <= '0;
    end else if ((state_r == SCAN) && (vec_r != '0)) begin
      spike_count <= spike_count + ($clog2(NUM_NEURONS+1))'(1);
    end else begin
      spike_count <= spike_count;
    end
  end
`else
  logic unused_capture_s;
  assign unused_capture_s = capture_s;
`endif

endmodule

// File: tb/tb_spike_dispatcher.sv
// Scoreboard bench for spike_dispatcher: stimulus pushes expected output
// events (address / clear / done, each tagged with its cycle) into a queue;
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_spike_dispatcher;

  logic        clock = 1'b0;
  logic        reset;
  logic        timestep_start;
  logic [31:0] spike_vector;
  logic [11:0] base_address;
  logic [11:0] source_address;
  logic        address_valid;
  logic        clear_out;
  logic        busy;
  logic        done;
`ifdef SPIKE_DISPATCHER_COUNT_EN
  logic [5:0]  spike_count;
`endif

  spike_dispatcher dut (
    .clock          (clock),
    .reset          (reset),
    .timestep_start (timestep_start),
    .spike_vector   (spike_vector),
    .base_address   (base_address),
    .source_address (source_address),
    .address_valid  (address_valid),
    .clear_out      (clear_out),
    .busy           (busy),
    .done           (done)
`ifdef SPIKE_DISPATCHER_COUNT_EN
    ,
    .spike_count    (spike_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int          kind;   // 0 address, 1 clear, 2 done
    logic [11:0] val;    // address, or spike count for done
    int          cyc;
  } ev_t;

  ev_t q[$];
  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;

  // Cycle counter; stimulus and monitor tag events with it.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [11:0] val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    q.push_back(e);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on any presented output.
  always @(negedge clock) begin
    int  kind;
    ev_t e;
    tests++;
    if (address_valid && clear_out) begin
      fails++;
      $display("FAIL overlap: address_valid and clear_out both high at cycle %0d", cyc);
    end
    tests++;
    if (!address_valid && source_address !== 12'hFFF) begin
      fails++;
      $display("FAIL idle_addr: got %0h expected fff at cycle %0d", source_address, cyc);
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      tests++;
      fails++;
      $display("FAIL missed: event kind %0d val %0h expected at cycle %0d, now %0d", e.kind, e.val, e.cyc, cyc);
    end
    if (address_valid || clear_out || done) begin
      kind = address_valid ? 0 : (clear_out ? 1 : 2);
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected: kind %0d addr %0h at cycle %0d, nothing expected", kind, source_address, cyc);
      end else begin
        e = q.pop_front();
        if (e.kind != kind || e.cyc != cyc || (kind == 0 && e.val !== source_address)) begin
          fails++;
          $display("FAIL event: got kind %0d addr %0h cycle %0d expected kind %0d addr %0h cycle %0d",
                   kind, source_address, cyc, e.kind, e.val, e.cyc);
        end
`ifdef SPIKE_DISPATCHER_COUNT_EN
        if (kind == 2 && e.kind == 2) begin
          tests++;
          if (spike_count !== 6'(e.val)) begin
            fails++;
            $display("FAIL spike_count: got %0d expected %0d", spike_count, e.val);
          end
        end
`endif
      end
    end
  end

  // One timestep dispatch with a hand-computed address list.
  task automatic dispatch(input logic [31:0] vec, input logic [11:0] base,
                          input logic [11:0] addrs[$], input bit second_start);
    int c, n, s;
    c = cyc;
    n = addrs.size();
    s = (n == 0) ? 1 : n;
    for (int k = 0; k < n; k++) push(0, addrs[k], c + 1 + k);
    push(1, 12'd0, c + 1 + s);
    push(1, 12'd0, c + 2 + s);
    push(2, 12'(n), c + 3 + s);
    spike_vector   = vec;
    base_address   = base;
    timestep_start = 1'b1;
    tick();
    timestep_start = 1'b0;
    spike_vector   = $urandom;
    base_address   = 12'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    while (cyc < c + 4 + s) begin
      if (second_start && cyc == c + 5) begin
        timestep_start = 1'b1;
        spike_vector   = 32'h0000_0003;
      end else begin
        timestep_start = 1'b0;
      end
      tick();
    end
    timestep_start = 1'b0;
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    logic [11:0] a[$];
    int c;
    reset          = 1'b1;
    timestep_start = 1'b0;
    spike_vector   = 32'd0;
    base_address   = 12'd0;
    tick();
    tick();
    chk("rst_addr",  32'(source_address), 32'hFFF);
    chk("rst_valid", 32'(address_valid), 32'd0);
    chk("rst_clear", 32'(clear_out), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // Three spikes: 8, 10, 16.
    a = '{12'd8, 12'd10, 12'd16};
    dispatch(32'h0000_0105, 12'd8, a, 1'b0);

    // Empty vector: one silent scan cycle, then clear and done.
    a = '{};
    dispatch(32'h0000_0000, 12'd8, a, 1'b0);

    // Address wrap.
    a = '{12'hFF0, 12'h00F};
    dispatch(32'h8000_0001, 12'hFF0, a, 1'b0);

    // All 32 neurons, second start on 5th scan cycle ignored.
    a = '{};
    for (int i = 0; i < 32; i++) a.push_back(12'h100 + 12'(i));
    dispatch(32'hFFFF_FFFF, 12'h100, a, 1'b1);

    // Single top neuron.
    a = '{12'h01F};
    dispatch(32'h8000_0000, 12'h000, a, 1'b0);

    // Reset on the 3rd scan cycle of 0xFF.
    c = cyc;
    push(0, 12'h040, c + 1);
    push(0, 12'h041, c + 2);
    push(0, 12'h042, c + 3);
    spike_vector   = 32'h0000_00FF;
    base_address   = 12'h040;
    timestep_start = 1'b1;
    tick();
    timestep_start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_addr",  32'(source_address), 32'hFFF);
    chk("midrst_valid", 32'(address_valid), 32'd0);
    chk("midrst_clear", 32'(clear_out), 32'd0);
    chk("midrst_busy",  32'(busy), 32'd0);
    chk("midrst_done",  32'(done), 32'd0);
    chk("midrst_queue", 32'(q.size()), 32'd0);
`ifdef SPIKE_DISPATCHER_COUNT_EN
    chk("midrst_count", 32'(spike_count), 32'd0);
`endif
    tick();
    chk("midrst_stays_idle", 32'(busy), 32'd0);

    // Fresh dispatch after the reset.
    a = '{12'h024, 12'h027};
    dispatch(32'h0000_0090, 12'h020, a, 1'b0);

    // Reset has priority over a simultaneous start.
    reset          = 1'b1;
    timestep_start = 1'b1;
    spike_vector   = 32'h0000_000F;
    tick();
    reset          = 1'b0;
    timestep_start = 1'b0;
    chk("rst_prio_busy",  32'(busy), 32'd0);
    chk("rst_prio_valid", 32'(address_valid), 32'd0);
    tick();
    chk("rst_prio_busy_next", 32'(busy), 32'd0);
    tick();
    tick();
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spike_dispatcher.md
SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 32, number of spike-vector bits scanned per timestep.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, width of emitted source address.
REQ-003 SHALL have parameter CLEAR_CYCLES, default 2, cycles the end-of-timestep clear is held high (legal 1..15).
REQ-004 SHALL have parameter IDLE_ADDR, default 12'hFFF, address driven when no spike is being emitted.
REQ-005 clock  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-007 timestep_start  input  1  one-cycle request to dispatch spike_vector.
REQ-008 spike_vector  input  NUM_NEURONS  per-neuron spike flags; bit i = neuron i fired.
REQ-009 base_address  input  ADDR_WIDTH  address of neuron 0; neuron i address = base_address + i.
REQ-010 source_address  output  ADDR_WIDTH  source address bus toward MAC units.
REQ-011 address_valid  output  1  high while source_address carries a spike address.
REQ-012 clear_out  output  1  end-of-timestep clear toward MAC units.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse when a timestep dispatch completes.

Function
REQ-015 SHALL implement states IDLE, SCAN, CLEAR, DONE.
REQ-016 IDLE: on timestep_start=1, SHALL capture spike_vector and base_address into internal registers and go to SCAN next cycle.
REQ-017 SCAN: each cycle SHALL emit the address of the lowest-index set bit in the captured vector, assert address_valid, and clear that bit.
REQ-018 SCAN SHALL go to CLEAR the cycle after the last set bit is emitted; if the captured vector is all-zero, SCAN SHALL last one cycle with address_valid=0 and go to CLEAR.
REQ-019 Dispatch latency: first address SHALL appear one cycle after timestep_start; N set bits occupy exactly N consecutive SCAN cycles.
REQ-020 Address arithmetic SHALL be base_address + index, modulo 2^ADDR_WIDTH (wrap, no saturation).
REQ-021 Whenever address_valid=0, source_address SHALL equal IDLE_ADDR.
REQ-022 CLEAR: clear_out=1 for exactly CLEAR_CYCLES cycles with source_address=IDLE_ADDR, then go to DONE.
REQ-023 DONE: done=1 for one cycle, then IDLE.
REQ-024 timestep_start while busy=1 SHALL be ignored; captured vector SHALL not change.
REQ-025 Changes to spike_vector/base_address after capture SHALL not affect the ongoing dispatch.
REQ-026 address_valid and clear_out SHALL never be high in the same cycle.

Reset
REQ-027 On reset=1 at a rising edge, state SHALL become IDLE regardless of current state, including mid-SCAN or mid-CLEAR.
REQ-028 Reset values: source_address=IDLE_ADDR, address_valid=0, clear_out=0, busy=0, done=0, captured vector=0, clear counter=0.
REQ-029 reset SHALL take priority over simultaneous timestep_start.

Configuration
REQ-030 Macro SPIKE_DISPATCHER_COUNT_EN SHALL, when defined, add output spike_count (width clog2(NUM_NEURONS+1)), zeroed at capture, incremented per emitted address, held through CLEAR/DONE/IDLE until next capture, reset to 0.
REQ-031 Without SPIKE_DISPATCHER_COUNT_EN, the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-032 Vector 32'h0000_0105, base 12'd8, start -> addresses 8,10,16 on three consecutive cycles with address_valid=1, then clear_out=1 two cycles, then done pulse; count=3 if enabled.
REQ-033 Vector 0, start -> one SCAN cycle with address_valid=0, clear_out 2 cycles, done; source_address stays 12'hFFF throughout.
REQ-034 Vector 32'h8000_0001, base 12'hFF0 -> addresses 12'hFF0 then 12'h00F (wrap).
REQ-035 Vector 32'hFFFF_FFFF, second start pulse on 5th SCAN cycle -> 32 addresses emitted once, second start ignored, single done.
REQ-036 reset asserted on 3rd SCAN cycle of vector 32'h0000_00FF -> next cycle all outputs at reset values; new start then dispatches fresh vector normally.
